// File: rtl/uart_pkg.sv
// Shared UART definitions: drain FSM state encoding and default widths/depths.
// Used by the transmit buffer and its storage sub-module.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_POP  = 2'd2,
        ST_CLR  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W byte storage: synchronous write, asynchronous read, no reset.
// No flow control of its own; the owner guards wr_en against overwriting live entries.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_TX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer feeding the UART transmitter over a four-phase data_w/ack/ack_clr handshake.
// Write to first request is 2 cycles; writes to a full buffer are dropped (sticky overrun) unless a pop frees a slot that cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_TX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                   i_uart_clk,
    input  logic                   i_reset_n,
    input  logic                   i_wr,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overrun,
    input  logic                   i_overrun_clr,
    output logic [DATA_W-1:0]      o_tx_data,
    output logic                   o_tx_data_w,
    input  logic                   i_tx_data_ack,
    output logic                   o_tx_data_ack_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;
    logic              drop;
    logic              load;
    logic              tx_data_w_nxt;
    logic              ack_clr_nxt;

    // The head byte is already latched in o_tx_data before POP, so a write
    // landing on the slot being freed cannot corrupt what the transmitter holds.
    assign pop  = (state == ST_POP);
    assign push = i_wr && ((count < FULL_CNT) || pop);
    assign drop = i_wr && !push;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (i_uart_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (i_wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        tx_data_w_nxt = 1'b0;
        ack_clr_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!o_empty) begin
                    state_nxt = ST_REQ;
                    load      = 1'b1;
                end
            end
            ST_REQ: begin
                if (i_tx_data_ack) begin
                    state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                state_nxt = ST_CLR;
            end
            ST_CLR: begin
                if (!i_tx_data_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered from the next state so they change with it.
        tx_data_w_nxt = (state_nxt == ST_REQ);
        ack_clr_nxt   = (state_nxt == ST_POP) || (state_nxt == ST_CLR);
    end

    always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state             <= ST_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            o_empty           <= 1'b1;
            o_full            <= 1'b0;
            o_overrun         <= 1'b0;
            o_tx_data         <= '0;
            o_tx_data_w       <= 1'b0;
            o_tx_data_ack_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                o_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                o_overrun <= 1'b0;
            end
            if (load) begin
                o_tx_data <= rd_data;
            end
            o_tx_data_w       <= tx_data_w_nxt;
            o_tx_data_ack_clr <= ack_clr_nxt;
        end
    end

    assign o_count = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a transmitter model acks requests and checks each sent byte
// against a queue of bytes the stimulus expects the buffer to accept.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       i_wr;
    logic [7:0] i_wr_data;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overrun;
    logic       i_overrun_clr;
    logic [7:0] o_tx_data;
    logic       o_tx_data_w;
    logic       i_tx_data_ack;
    logic       o_tx_data_ack_clr;

    uart_tx_fifo #(
        .DEPTH  (16),
        .DATA_W (8)
    ) dut (
        .i_uart_clk        (clk),
        .i_reset_n         (rst_n),
        .i_wr              (i_wr),
        .i_wr_data         (i_wr_data),
        .o_full            (o_full),
        .o_empty           (o_empty),
        .o_count           (o_count),
        .o_overrun         (o_overrun),
        .i_overrun_clr     (i_overrun_clr),
        .o_tx_data         (o_tx_data),
        .o_tx_data_w       (o_tx_data_w),
        .i_tx_data_ack     (i_tx_data_ack),
        .o_tx_data_ack_clr (o_tx_data_ack_clr)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    bit         stall     = 1'b0;
    int         ack_delay = 2;
    int         mstate    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit accept, input bit clr = 1'b0);
        i_wr          = 1'b1;
        i_wr_data     = d;
        i_overrun_clr = clr;
        if (accept) exp_q.push_back(d);
        @(posedge clk); #1;
        i_wr          = 1'b0;
        i_overrun_clr = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            if (exp_q.size() == 0 && o_empty && !o_tx_data_w && !o_tx_data_ack_clr && mstate == 0)
                done = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, "_drained"}, {31'd0, done}, 32'd1);
        check({tag, "_count0"}, o_count, 0);
        check({tag, "_empty"}, o_empty, 1);
    endtask

    // Transmitter model: raises ack ack_delay cycles after data_w, drops it one
    // cycle after seeing ack_clr, and checks each acked byte against the queue.
    initial begin : xmtr
        int         dly;
        logic [7:0] held;
        logic [7:0] exp_b;
        i_tx_data_ack = 1'b0;
        dly  = 0;
        held = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mstate        = 0;
                i_tx_data_ack = 1'b0;
            end else begin
                if (o_tx_data_w || o_tx_data_ack_clr)
                    check("w_clr_excl", {31'd0, o_tx_data_w & o_tx_data_ack_clr}, 0);
                case (mstate)
                    0: if (o_tx_data_w) begin
                        held   = o_tx_data;
                        dly    = 1;
                        mstate = 1;
                        if (exp_q.size() == 0) check("unexpected_tx", o_tx_data, 32'hFFFF);
                    end
                    1: begin
                        check("req_stable", o_tx_data, held);
                        if (!stall) begin
                            if (dly >= ack_delay) begin
                                i_tx_data_ack = 1'b1;
                                if (exp_q.size() != 0) begin
                                    exp_b = exp_q.pop_front();
                                    check("tx_byte", held, exp_b);
                                end
                                mstate = 2;
                            end else begin
                                dly++;
                            end
                        end
                    end
                    2: if (o_tx_data_ack_clr) begin
                        check("pop_w_low", o_tx_data_w, 0);
                        mstate = 3;
                    end
                    3: begin
                        check("ack_clr_hold", o_tx_data_ack_clr, 1);
                        i_tx_data_ack = 1'b0;
                        mstate = 4;
                    end
                    default: begin
                        check("ack_clr_drop", o_tx_data_ack_clr, 0);
                        mstate = 0;
                    end
                endcase
            end
        end
    end

    initial begin : main
        int  n;
        bit  seen;
        rst_n         = 1'b0;
        i_wr          = 1'b0;
        i_wr_data     = '0;
        i_overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_count", o_count, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_data_w", o_tx_data_w, 0);
        check("rst_ack_clr", o_tx_data_ack_clr, 0);
        check("rst_tx_data", o_tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte, ack two cycles after request.
        ack_delay = 2;
        wr_byte(8'h41, 1'b1);
        check("t1_empty_fall", o_empty, 0);
        check("t1_count1", o_count, 1);
        check("t1_w_not_yet", o_tx_data_w, 0);
        @(posedge clk); #1;
        check("t1_w_rise", o_tx_data_w, 1);
        check("t1_tx_data", o_tx_data, 8'h41);
        check("t1_count_req", o_count, 1);
        wait_drain("t1", 50);

        // Fill with ack stalled, then overflow by one.
        stall = 1'b1;
        for (int i = 0; i < 16; i++) wr_byte(8'(i), 1'b1);
        check("t2_full", o_full, 1);
        check("t2_count16", o_count, 16);
        wr_byte(8'hAA, 1'b0);
        check("t2_overrun", o_overrun, 1);
        check("t2_count_hold", o_count, 16);
        stall = 1'b0;
        wait_drain("t2", 400);
        check("t2_overrun_sticky", o_overrun, 1);
        i_overrun_clr = 1'b1;
        @(posedge clk); #1;
        i_overrun_clr = 1'b0;
        check("t2_overrun_clr", o_overrun, 0);

        // Full again: drop with simultaneous clear, then a write in the POP cycle.
        stall = 1'b1;
        for (int i = 0; i < 16; i++) wr_byte(8'(8'h10 + i), 1'b1);
        wr_byte(8'hEE, 1'b0);
        check("t3_overrun_set", o_overrun, 1);
        wr_byte(8'hEF, 1'b0, 1'b1);
        check("t3_set_wins", o_overrun, 1);
        i_overrun_clr = 1'b1;
        @(posedge clk); #1;
        i_overrun_clr = 1'b0;
        check("t3_cleared", o_overrun, 0);
        stall = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            if (o_tx_data_ack_clr) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("t3_pop_seen", {31'd0, seen}, 1);
        wr_byte(8'h55, 1'b1);
        check("t3_count_stays", o_count, 16);
        check("t3_full_stays", o_full, 1);
        check("t3_no_overrun", o_overrun, 0);
        wait_drain("t3", 400);

        // Twenty bytes in two drains so the pointers wrap.
        ack_delay = 1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) wr_byte(8'($urandom_range(0, 255)), 1'b1);
            wait_drain("t4", 300);
        end

        // Reset while a request is outstanding with five bytes queued.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) wr_byte(8'(8'hC0 + i), 1'b1);
        @(posedge clk); #1;
        check("t5_in_req", o_tx_data_w, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_w_low", o_tx_data_w, 0);
        check("t5_count0", o_count, 0);
        check("t5_empty", o_empty, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_stale_w", o_tx_data_w, 0);
        check("t5_post_count", o_count, 0);
        check("t5_post_empty", o_empty, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
